// File: rtl/pll_phase_ctrl_pkg.sv
// pll_phase_pkg: shared states, PHASESEL/PHASEDIR codes and phase helpers for pll_phase_ctrl.
// Optional feature macro: PLL_PHASE_CTRL_RELOCK_EN adds the RST_PLL state.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        IDLE,
        SETUP,
        STEP_LO,
        STEP_HI,
        SETTLE,
        DONE
`ifdef PLL_PHASE_CTRL_RELOCK_EN
        , RST_PLL
`endif
    } state_t;

    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;
    localparam logic [1:0] SEL_CLKOP  = 2'b11;

    localparam logic DIR_DELAY   = 1'b0;
    localparam logic DIR_ADVANCE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wrap by compare so any modulus below 64 works, not just powers of two
    function automatic logic [5:0] pos_step(input logic [5:0] pos, input logic dir, input int modulus);
        logic [5:0] top;
        top = 6'(modulus - 1);
        if (dir == DIR_DELAY)
            return (pos == top) ? 6'd0 : pos + 6'd1;
        return (pos == 6'd0) ? top : pos - 6'd1;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// pll_phase_ctrl_if: phase-step request/response bus between calibration logic and pll_phase_ctrl.
interface pll_phase_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_dir;
    logic [1:0] req_sel;
    logic [7:0] req_steps;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_dir, req_sel, req_steps,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_dir, req_sel, req_steps,
        output req_ready, done, err
    );

endinterface

// File: rtl/pll_phase_ctrl_lock_sync.sv
// lock_sync: two-flop synchronizer bringing the raw PLL LOCK into the clk domain.
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; reset to "unlocked" so nothing starts before lock is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: EHXPLLL dynamic phase-shift sequencer with CLKOS position tracking and lock supervision.
// Optional feature macro: PLL_PHASE_CTRL_RELOCK_EN enables lock-timeout PLL reset (RST_PLL state).
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int STEP_W     = 4,
    parameter int GAP_W      = 4,
    parameter int SETTLE_CYC = 16,
    parameter int PHASE_MOD  = 40,
    parameter int LOCK_TO    = 1024,
    parameter int RST_CYC    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_locked,
    pll_phase_ctrl_if.slave        bus,
    output logic                   o_lock_ok,
    output logic [5:0]             o_phase_pos,
    output logic [1:0]             o_pll_phasesel,
    output logic                   o_pll_phasedir,
    output logic                   o_pll_phasestep,
    output logic                   o_pll_phaseloadreg,
    output logic                   o_pll_rst
);

    // One down-counter times every state, including the lock timeout in WAIT_LOCK
    localparam int TMR_MAX = max_int(max_int(max_int(STEP_W, GAP_W), max_int(SETTLE_CYC, LOCK_TO)), RST_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t             r_state;
    state_t             w_next;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_load;
    logic [7:0]         r_rem;
    logic [5:0]         r_pos;
    logic [1:0]         r_sel;
    logic               r_dir;
    logic               r_ready;
    logic               r_done;
    logic               r_err;
    logic               r_step;
    logic               w_lock_ok;
    logic               w_busy;
    logic               w_tmr_zero;
    logic               w_accept;
    logic               w_step_edge;

    lock_sync u_lock_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_locked),
        .o_sync  (w_lock_ok)
    );

    // Next-state logic; lock loss in any stepping state aborts straight to WAIT_LOCK
    always_comb begin
        w_next      = r_state;
        w_busy      = (r_state == SETUP) || (r_state == STEP_LO) || (r_state == STEP_HI) || (r_state == SETTLE);
        w_tmr_zero  = (r_tmr == '0);
        w_accept    = (r_state == IDLE) && bus.req_valid && r_ready;
        if (w_busy && !w_lock_ok) begin
            w_next = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lock_ok)
                        w_next = IDLE;
`ifdef PLL_PHASE_CTRL_RELOCK_EN
                    else if (w_tmr_zero)
                        w_next = RST_PLL;
`endif
                end
                // An accepted request wins over a same-cycle lock drop; the busy path then aborts with err
                IDLE:    w_next = w_accept ? ((bus.req_steps == 8'd0) ? DONE : SETUP) : (!w_lock_ok ? WAIT_LOCK : IDLE);
                SETUP:   w_next = STEP_LO;
                STEP_LO: w_next = w_tmr_zero ? STEP_HI : STEP_LO;
                STEP_HI: w_next = w_tmr_zero ? ((r_rem == 8'd1) ? SETTLE : STEP_LO) : STEP_HI;
                SETTLE:  w_next = w_tmr_zero ? DONE : SETTLE;
                DONE:    w_next = IDLE;
`ifdef PLL_PHASE_CTRL_RELOCK_EN
                RST_PLL: w_next = w_tmr_zero ? WAIT_LOCK : RST_PLL;
`endif
                default: w_next = WAIT_LOCK;
            endcase
        end
        w_step_edge = (r_state == STEP_LO) && (w_next == STEP_HI);
    end

    // Timer reload value for the state being entered
    always_comb begin
        w_load = TMR_W'(LOCK_TO - 1);
        if (w_next == STEP_LO)
            w_load = TMR_W'(STEP_W - 1);
        if (w_next == STEP_HI)
            w_load = TMR_W'(GAP_W - 1);
        if (w_next == SETTLE)
            w_load = TMR_W'(SETTLE_CYC - 1);
`ifdef PLL_PHASE_CTRL_RELOCK_EN
        if (w_next == RST_PLL)
            w_load = TMR_W'(RST_CYC - 1);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= WAIT_LOCK;
        else
            r_state <= w_next;
    end

    // Timer: reload on every state change, count down to zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tmr <= TMR_W'(LOCK_TO - 1);
        else if (w_next != r_state)
            r_tmr <= w_load;
        else if (!w_tmr_zero)
            r_tmr <= r_tmr - TMR_W'(1);
    end

    // Request latch, remaining-step count and CLKOS phase accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= 8'd0;
            r_sel <= SEL_CLKOS;
            r_dir <= DIR_DELAY;
            r_pos <= 6'd0;
        end else begin
            if (w_accept) begin
                r_rem <= bus.req_steps;
                r_sel <= bus.req_sel;
                r_dir <= bus.req_dir;
            end else if ((r_state == STEP_HI) && w_tmr_zero) begin
                r_rem <= r_rem - 8'd1;
            end
            if (w_step_edge && (r_sel == SEL_CLKOS))
                r_pos <= pos_step(r_pos, r_dir, PHASE_MOD);
`ifdef PLL_PHASE_CTRL_RELOCK_EN
            else if (w_next == RST_PLL)
                r_pos <= 6'd0;
`endif
        end
    end

    // Registered outputs decoded from the next state; PHASESTEP idles high and resets high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_step  <= 1'b1;
        end else begin
            r_ready <= (w_next == IDLE) && w_lock_ok;
            r_done  <= (w_next == DONE);
            r_err   <= w_busy && !w_lock_ok;
            r_step  <= (w_next != STEP_LO);
        end
    end

`ifdef PLL_PHASE_CTRL_RELOCK_EN
    logic r_rst;

    // PLL reset pulse while in RST_PLL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rst <= 1'b0;
        else
            r_rst <= (w_next == RST_PLL);
    end

    assign o_pll_rst = r_rst;
`else
    assign o_pll_rst = 1'b0;
`endif

    assign bus.req_ready      = r_ready;
    assign bus.done           = r_done;
    assign bus.err            = r_err;
    assign o_lock_ok          = w_lock_ok;
    assign o_phase_pos        = r_pos;
    assign o_pll_phasesel     = r_sel;
    assign o_pll_phasedir     = r_dir;
    assign o_pll_phasestep    = r_step;
    assign o_pll_phaseloadreg = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: directed self-checking bench for pll_phase_ctrl at default parameters.
module tb_pll_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b1;
    logic       lock_ok;
    logic [5:0] pos;
    logic [1:0] psel;
    logic       pdir;
    logic       pstep;
    logic       pload;
    logic       prst;
    int         tests = 0;
    int         fails = 0;

    pll_phase_ctrl_if bus();

    pll_phase_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_locked           (locked),
        .bus                (bus),
        .o_lock_ok          (lock_ok),
        .o_phase_pos        (pos),
        .o_pll_phasesel     (psel),
        .o_pll_phasedir     (pdir),
        .o_pll_phasestep    (pstep),
        .o_pll_phaseloadreg (pload),
        .o_pll_rst          (prst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request and watch it until done; the expected PHASESTEP waveform assumes STEP_W=GAP_W=4
    task automatic run_req(input logic dir, input logic [1:0] sel, input int steps,
                           output int lat, output int falls, output int bad);
        int  n;
        int  w;
        logic prev;
        logic exp_lo;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_req", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_dir   = dir;
        bus.req_sel   = sel;
        bus.req_steps = 8'(steps);
        tick();
        bus.req_valid = 1'b0;
        n = 1;
        falls = 0;
        bad = 0;
        prev = 1'b1;
        while (bus.done !== 1'b1 && n < 400) begin
            exp_lo = (steps > 0) && (n >= 2) && (n < 2 + 8 * steps) && (((n - 2) % 8) < 4);
            if (pstep !== ~exp_lo) bad++;
            if (steps > 0 && (psel !== sel || pdir !== dir)) bad++;
            if (bus.err !== 1'b0 || bus.req_ready !== 1'b0) bad++;
            if (prev === 1'b1 && pstep === 1'b0) falls++;
            prev = pstep;
            tick();
            n++;
        end
        lat = n;
    endtask

    initial begin
        int lat;
        int falls;
        int bad;
        int errs;
        int dones;
        int w;
        bus.req_valid = 1'b0;
        bus.req_dir   = 1'b0;
        bus.req_sel   = 2'b00;
        bus.req_steps = 8'd0;
        repeat (3) tick();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_lock_ok", lock_ok, 0);
        chk("rst_pos", pos, 0);
        chk("rst_sel_dir", {psel, pdir}, 0);
        chk("rst_step", pstep, 1);
        chk("rst_loadreg", pload, 1);
        chk("rst_pll_rst", prst, 0);

        rst_n = 1'b1;
        tick();
        chk("lock_lat1_ready", bus.req_ready, 0);
        tick();
        chk("lock_lat2_ready", bus.req_ready, 0);
        chk("lock_lat2_lock_ok", lock_ok, 1);
        tick();
        chk("lock_lat3_ready", bus.req_ready, 1);
        chk("lock_lat3_step", pstep, 1);

        run_req(1'b0, 2'b00, 3, lat, falls, bad);
        chk("s3_latency", lat, 42);
        chk("s3_pulses", falls, 3);
        chk("s3_waveform", bad, 0);
        chk("s3_pos", pos, 3);
        tick();
        chk("s3_done_one_cycle", bus.done, 0);
        chk("s3_ready_back", bus.req_ready, 1);

        run_req(1'b1, 2'b00, 2, lat, falls, bad);
        chk("adv2_latency", lat, 34);
        chk("adv2_waveform", bad, 0);
        chk("adv2_pos", pos, 1);

        run_req(1'b1, 2'b00, 2, lat, falls, bad);
        chk("wrap_down_pulses", falls, 2);
        chk("wrap_down_pos", pos, 39);

        run_req(1'b0, 2'b01, 5, lat, falls, bad);
        chk("sel01_latency", lat, 58);
        chk("sel01_pulses", falls, 5);
        chk("sel01_waveform", bad, 0);
        chk("sel01_pos_held", pos, 39);
        chk("sel01_phasesel", psel, 1);

        run_req(1'b0, 2'b00, 0, lat, falls, bad);
        chk("zero_latency", lat, 1);
        chk("zero_no_step", falls, 0);
        chk("zero_pos", pos, 39);

        run_req(1'b0, 2'b00, 1, lat, falls, bad);
        chk("wrap_up_latency", lat, 26);
        chk("wrap_up_pos", pos, 0);

        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("lk_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_dir   = 1'b0;
        bus.req_sel   = 2'b00;
        bus.req_steps = 8'd4;
        tick();
        bus.req_valid = 1'b0;
        repeat (9) tick();
        chk("lk_second_step_low", pstep, 0);
        chk("lk_one_step_counted", pos, 1);
        locked = 1'b0;
        tick();
        tick();
        chk("lk_sync_low", lock_ok, 0);
        chk("lk_no_err_yet", bus.err, 0);
        bus.req_valid = 1'b1;
        bus.req_steps = 8'd0;
        tick();
        chk("lk_err_pulse", bus.err, 1);
        chk("lk_step_high", pstep, 1);
        chk("lk_no_done", bus.done, 0);
        errs = 0;
        dones = 0;
        repeat (20) begin
            tick();
            errs += int'(bus.err);
            dones += int'(bus.done) + int'(bus.req_ready);
        end
        chk("lk_err_single", errs, 0);
        chk("lk_no_done_no_ready", dones, 0);
        chk("lk_pos_kept", pos, 1);
        bus.req_valid = 1'b0;
        locked = 1'b1;
        tick();
        tick();
        chk("relock2_ready", bus.req_ready, 0);
        tick();
        chk("relock3_ready", bus.req_ready, 1);

        run_req(1'b0, 2'b00, 2, lat, falls, bad);
        chk("after_relock_pos", pos, 3);
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        bus.req_valid = 1'b1;
        bus.req_steps = 8'd2;
        tick();
        bus.req_valid = 1'b0;
        repeat (2) tick();
        chk("arst_step_low", pstep, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_step_forced", pstep, 1);
        chk("arst_pos", pos, 0);
        chk("arst_ready", bus.req_ready, 0);
        tick();
        rst_n = 1'b1;

`ifdef PLL_PHASE_CTRL_RELOCK_EN
        run_req(1'b0, 2'b00, 1, lat, falls, bad);
        chk("rl_pos_pre", pos, 1);
        locked = 1'b0;
        w = 0;
        while (prst !== 1'b1 && w < 2000) begin
            tick();
            w++;
        end
        chk("rl_rst_seen", prst, 1);
        chk("rl_pos_cleared", pos, 0);
        w = 0;
        while (prst === 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("rl_rst_width", w, 8);
        w = 0;
        while (prst !== 1'b1 && w < 2000) begin
            tick();
            w++;
        end
        chk("rl_repeat_gap", w, 1024);
        locked = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
